// File: rtl/softmax_pkg.sv
// Shared types and defaults for the softmax input front-end.
// Element/scale typedefs, FSM state encoding and default bus geometry.
package softmax_pkg;

    localparam int BUS_NUM_DEFAULT  = 8;
    localparam int IN_LANES_DEFAULT = 2;
    localparam int FIXED_W_DEFAULT  = 8;
    localparam int SCALE_W_DEFAULT  = 5;
    localparam int LEN_W_DEFAULT    = 10;

    typedef logic signed [FIXED_W_DEFAULT-1:0] fixed_t;
    typedef logic signed [SCALE_W_DEFAULT-1:0] scale_pos_t;

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/softmax_in_packer_lane_packer.sv
// Packs narrow input beats into a wide output beat.
// Owns the pack buffer, fill pointer, lane merge and valid-mask generation.
module lane_packer
    import softmax_pkg::*;
#(
    parameter int BUS_NUM  = BUS_NUM_DEFAULT,
    parameter int IN_LANES = IN_LANES_DEFAULT,
    parameter int W        = FIXED_W_DEFAULT,
    parameter int CNT_W    = $clog2(IN_LANES + 1),
    parameter int PTR_W    = $clog2(BUS_NUM + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_hs,
    input  logic                  i_last,
    input  logic [CNT_W-1:0]      i_take,
    input  logic [IN_LANES*W-1:0] i_data,
    output logic [BUS_NUM*W-1:0]  o_data,
    output logic [BUS_NUM-1:0]    o_vld,
    output logic                  o_last
);

    logic [BUS_NUM*W-1:0] r_buf;
    logic [BUS_NUM*W-1:0] r_data;
    logic [BUS_NUM-1:0]   r_vld;
    logic                 r_last;
    logic [PTR_W-1:0]     r_ptr;

    logic [BUS_NUM*W-1:0] w_merged;
    logic [BUS_NUM-1:0]   w_mask;
    logic [PTR_W-1:0]     w_filled;
    logic                 w_full;
    logic                 w_emit;

    assign w_filled = r_ptr + PTR_W'(i_take);
    assign w_full   = (r_ptr + PTR_W'(IN_LANES)) == PTR_W'(BUS_NUM);
    assign w_emit   = i_hs & (i_last | w_full);

    // Lanes at or above the fill level are forced to zero so the
    // emitted beat never carries stale or untaken elements.
    always_comb begin
        w_merged = r_buf;
        w_mask   = '0;
        for (int j = 0; j < IN_LANES; j++) begin
            if ((int'(r_ptr) + j) < BUS_NUM) begin
                w_merged[(int'(r_ptr) + j)*W +: W] = i_data[j*W +: W];
            end
        end
        for (int l = 0; l < BUS_NUM; l++) begin
            w_mask[l] = PTR_W'(l) < w_filled;
            if (!w_mask[l]) begin
                w_merged[l*W +: W] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf  <= '0;
            r_data <= '0;
            r_vld  <= '0;
            r_last <= 1'b0;
            r_ptr  <= '0;
        end else begin
            r_data <= '0;
            r_vld  <= '0;
            r_last <= 1'b0;
            if (w_emit) begin
                r_data <= w_merged;
                r_vld  <= w_mask;
                r_last <= i_last;
                r_buf  <= '0;
                r_ptr  <= '0;
            end else if (i_hs) begin
                r_buf  <= w_merged;
                r_ptr  <= r_ptr + PTR_W'(IN_LANES);
            end
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld;
    assign o_last = r_last;

endmodule

// File: rtl/softmax_in_packer.sv
// Softmax front-end: vector FSM, length tracking and scale-position issue.
// Element packing is delegated to lane_packer.
module softmax_in_packer
    import softmax_pkg::*;
#(
    parameter int BUS_NUM          = BUS_NUM_DEFAULT,
    parameter int IN_LANES         = IN_LANES_DEFAULT,
    parameter int FIXED_DATA_WIDTH = FIXED_W_DEFAULT,
    parameter int SCALA_POS_WIDTH  = SCALE_W_DEFAULT,
    parameter int LEN_WIDTH        = LEN_W_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cfg_start,
    input  logic [LEN_WIDTH-1:0]                 cfg_len,
    input  logic [SCALA_POS_WIDTH-1:0]           cfg_in_scale_pos,
    input  logic [SCALA_POS_WIDTH-1:0]           cfg_out_scale_pos,
    input  logic [IN_LANES*FIXED_DATA_WIDTH-1:0] in_data,
    input  logic [$clog2(IN_LANES+1)-1:0]        in_cnt,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 stall,
    output logic [SCALA_POS_WIDTH-1:0]           in_scale_pos,
    output logic                                 in_scale_pos_vld,
    output logic [SCALA_POS_WIDTH-1:0]           out_scale_pos,
    output logic                                 out_scale_pos_vld,
    output logic [BUS_NUM*FIXED_DATA_WIDTH-1:0]  out_fixed_data,
    output logic [BUS_NUM-1:0]                   out_fixed_data_vld,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int W     = FIXED_DATA_WIDTH;
    localparam int CNT_W = $clog2(IN_LANES + 1);

    state_t                     r_state;
    state_t                     w_next;
    logic [LEN_WIDTH-1:0]       r_remaining;
    logic [SCALA_POS_WIDTH-1:0] r_in_sp;
    logic [SCALA_POS_WIDTH-1:0] r_out_sp;
    logic                       r_err;
    logic                       r_done;

    logic                  w_hs;
    logic                  w_short;
    logic                  w_last;
    logic [CNT_W-1:0]      w_cnt;
    logic [CNT_W-1:0]      w_base;
    logic [CNT_W-1:0]      w_take;
    logic [IN_LANES*W-1:0] w_data;

    // A short beat that cannot end the vector is padded to a full beat.
    always_comb begin
        w_cnt   = (in_cnt > CNT_W'(IN_LANES)) ? CNT_W'(IN_LANES) : in_cnt;
        w_short = (w_cnt < CNT_W'(IN_LANES))
                  && (LEN_WIDTH'(w_cnt) < r_remaining);
        w_base  = w_short ? CNT_W'(IN_LANES) : w_cnt;
        w_take  = (r_remaining < LEN_WIDTH'(w_base))
                  ? CNT_W'(r_remaining) : w_base;
        w_last  = r_remaining == LEN_WIDTH'(w_take);
        w_data  = '0;
        for (int j = 0; j < IN_LANES; j++) begin
            if (CNT_W'(j) < w_cnt) begin
                w_data[j*W +: W] = in_data[j*W +: W];
            end
        end
    end

    assign w_hs = in_valid & in_ready;

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cfg_start && (cfg_len != '0)) begin
                    w_next = CFG;
                end
            end
            CFG: begin
                w_next = RUN;
            end
            RUN: begin
                in_ready = ~stall;
                if (in_valid && !stall && w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_in_sp     <= '0;
            r_out_sp    <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= r_state == DONE;
            if ((r_state == IDLE) && cfg_start) begin
                if (cfg_len != '0) begin
                    r_remaining <= cfg_len;
                    r_in_sp     <= cfg_in_scale_pos;
                    r_out_sp    <= cfg_out_scale_pos;
                    r_err       <= 1'b0;
                end else begin
                    r_err       <= 1'b1;
                end
            end
            if (w_hs) begin
                r_remaining <= r_remaining - LEN_WIDTH'(w_take);
                if (w_short) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    lane_packer #(
        .BUS_NUM  (BUS_NUM),
        .IN_LANES (IN_LANES),
        .W        (W)
    ) u_lane_packer (
        .clk    (clk),
        .rst    (rst),
        .i_hs   (w_hs),
        .i_last (w_last),
        .i_take (w_take),
        .i_data (w_data),
        .o_data (out_fixed_data),
        .o_vld  (out_fixed_data_vld),
        .o_last (out_last)
    );

    assign in_scale_pos      = r_in_sp;
    assign out_scale_pos     = r_out_sp;
    assign in_scale_pos_vld  = r_state == CFG;
    assign out_scale_pos_vld = r_state == CFG;
    assign busy              = r_state != IDLE;
    assign done              = r_done;
    assign err               = r_err;

endmodule

// File: tb/tb_softmax_in_packer.sv
// Scoreboard bench for softmax_in_packer.
// Expected output beats are queued as stimulus is driven.
module tb_softmax_in_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [9:0]  cfg_len;
    logic [4:0]  cfg_in_scale_pos;
    logic [4:0]  cfg_out_scale_pos;
    logic [15:0] in_data;
    logic [1:0]  in_cnt;
    logic        in_valid;
    logic        in_ready;
    logic        stall;
    logic [4:0]  in_scale_pos;
    logic        in_scale_pos_vld;
    logic [4:0]  out_scale_pos;
    logic        out_scale_pos_vld;
    logic [63:0] out_fixed_data;
    logic [7:0]  out_fixed_data_vld;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  v;
        logic        l;
    } beat_t;

    beat_t q[$];
    beat_t m_exp;
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    t0     = 0;

    softmax_in_packer dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_start          (cfg_start),
        .cfg_len            (cfg_len),
        .cfg_in_scale_pos   (cfg_in_scale_pos),
        .cfg_out_scale_pos  (cfg_out_scale_pos),
        .in_data            (in_data),
        .in_cnt             (in_cnt),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .stall              (stall),
        .in_scale_pos       (in_scale_pos),
        .in_scale_pos_vld   (in_scale_pos_vld),
        .out_scale_pos      (out_scale_pos),
        .out_scale_pos_vld  (out_scale_pos_vld),
        .out_fixed_data     (out_fixed_data),
        .out_fixed_data_vld (out_fixed_data_vld),
        .out_last           (out_last),
        .busy               (busy),
        .done               (done),
        .err                (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && out_fixed_data_vld !== 8'h00) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got data=%h mask=%h last=%b, required no beat",
                         out_fixed_data, out_fixed_data_vld, out_last);
            end else begin
                m_exp = q.pop_front();
                if ({out_fixed_data, out_fixed_data_vld, out_last} !== m_exp) begin
                    errors++;
                    $display("FAIL beat: got data=%h mask=%h last=%b, required data=%h mask=%h last=%b",
                             out_fixed_data, out_fixed_data_vld, out_last,
                             m_exp.d, m_exp.v, m_exp.l);
                end
            end
        end
    end

    function automatic logic [63:0] seq_data(input int first, input int n);
        logic [63:0] r;
        r = '0;
        for (int l = 0; l < n; l++) r[l*8 +: 8] = 8'(first + l);
        return r;
    endfunction

    function automatic beat_t mk(input logic [63:0] d, input int n, input logic l);
        beat_t b;
        b.d = d;
        b.v = 8'((1 << n) - 1);
        b.l = l;
        return b;
    endfunction

    task automatic start_vec(input int len, input logic [4:0] isp, input logic [4:0] osp);
        cfg_start         = 1'b1;
        cfg_len           = 10'(len);
        cfg_in_scale_pos  = isp;
        cfg_out_scale_pos = osp;
        t0                = cyc;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic [1:0] c);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_cnt   = c;
        #1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_start = 1'b0; cfg_len = '0;
        cfg_in_scale_pos = '0; cfg_out_scale_pos = '0;
        in_data = '0; in_cnt = '0; in_valid = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_fixed_data_vld, out_fixed_data} !== 72'h0) begin
            errors++;
            $display("FAIL reset_out: got mask=%h data=%h, required 0", out_fixed_data_vld, out_fixed_data);
        end
        checks++;
        if ({busy, done, err, in_ready, out_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/done/err/rdy/last=%b, required 00000",
                     {busy, done, err, in_ready, out_last});
        end
        checks++;
        if ({in_scale_pos_vld, out_scale_pos_vld, in_scale_pos, out_scale_pos} !== 12'h0) begin
            errors++;
            $display("FAIL reset_scale: got %h, required 0",
                     {in_scale_pos_vld, out_scale_pos_vld, in_scale_pos, out_scale_pos});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        start_vec(0, 5'd1, 5'd2);
        checks++;
        if ({err, busy, in_scale_pos_vld} !== 3'b100) begin
            errors++;
            $display("FAIL zero_len: got err/busy/cfgvld=%b, required 100", {err, busy, in_scale_pos_vld});
        end
    endtask

    task automatic test_basic();
        start_vec(8, 5'd3, 5'h1C);
        checks++;
        if ({in_scale_pos_vld, out_scale_pos_vld, in_scale_pos, out_scale_pos} !== {2'b11, 5'd3, 5'h1C}) begin
            errors++;
            $display("FAIL cfg_pulse: got vld=%b%b isp=%h osp=%h, required vld=11 isp=03 osp=1c",
                     in_scale_pos_vld, out_scale_pos_vld, in_scale_pos, out_scale_pos);
        end
        checks++;
        if ({err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL start_err_clear: got err/busy=%b, required 01", {err, busy});
        end
        send_beat(16'h0201, 2'd2);
        send_beat(16'h0403, 2'd2);
        send_beat(16'h0605, 2'd2);
        q.push_back(mk(seq_data(1, 8), 8, 1'b1));
        send_beat(16'h0807, 2'd2);
        checks++;
        if ({out_fixed_data_vld, out_last, done} !== {8'hFF, 1'b1, 1'b0} || (cyc - t0) != 6) begin
            errors++;
            $display("FAIL basic_latency: got mask=%h last=%b done=%b cycles=%0d, required ff 1 0 6",
                     out_fixed_data_vld, out_last, done, cyc - t0);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, out_fixed_data_vld} !== {2'b10, 8'h00}) begin
            errors++;
            $display("FAIL basic_done: got done=%b busy=%b mask=%h, required 1 0 00",
                     done, busy, out_fixed_data_vld);
        end
    endtask

    task automatic test_partial();
        start_vec(13, 5'd0, 5'd0);
        for (int k = 0; k < 6; k++) begin
            if (k == 3) q.push_back(mk(seq_data(1, 8), 8, 1'b0));
            send_beat({8'(2*k + 2), 8'(2*k + 1)}, 2'd2);
        end
        q.push_back(mk(seq_data(9, 5), 5, 1'b1));
        send_beat({8'hEE, 8'd13}, 2'd1);
        checks++;
        if ({out_fixed_data_vld, out_last, out_fixed_data[63:40]} !== {8'h1F, 1'b1, 24'h0}) begin
            errors++;
            $display("FAIL partial_tail: got mask=%h last=%b hi=%h, required 1f 1 000000",
                     out_fixed_data_vld, out_last, out_fixed_data[63:40]);
        end
        @(negedge clk);
        checks++;
        if ({done, err} !== 2'b10) begin
            errors++;
            $display("FAIL partial_done: got done/err=%b, required 10", {done, err});
        end
    endtask

    task automatic test_len3();
        start_vec(3, 5'd7, 5'd9);
        send_beat(16'h0201, 2'd2);
        q.push_back(mk(seq_data(1, 3), 3, 1'b1));
        send_beat(16'h0403, 2'd2);
        checks++;
        if ({out_fixed_data_vld, out_fixed_data[63:24], err} !== {8'h07, 40'h0, 1'b0}) begin
            errors++;
            $display("FAIL len3: got mask=%h hi=%h err=%b, required 07 0 0",
                     out_fixed_data_vld, out_fixed_data[63:24], err);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        start_vec(8, 5'd4, 5'd5);
        send_beat(16'h0201, 2'd2);
        send_beat(16'h0403, 2'd2);
        send_beat(16'h0605, 2'd2);
        q.push_back(mk(seq_data(1, 8), 8, 1'b1));
        stall    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0807;
        in_cnt   = 2'd2;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if ({in_ready, out_fixed_data_vld} !== 9'h0) begin
                errors++;
                $display("FAIL stall_hold%0d: got rdy=%b mask=%h, required 0 00",
                         s, in_ready, out_fixed_data_vld);
            end
            @(negedge clk);
        end
        stall = 1'b0;
        send_beat(16'h0807, 2'd2);
        checks++;
        if (out_fixed_data_vld !== 8'hFF || (cyc - t0) != 9) begin
            errors++;
            $display("FAIL stall_latency: got mask=%h cycles=%0d, required ff 9",
                     out_fixed_data_vld, cyc - t0);
        end
        @(negedge clk);
    endtask

    task automatic test_short();
        logic [63:0] d;
        start_vec(8, 5'd1, 5'd1);
        send_beat(16'h0201, 2'd2);
        send_beat({8'hAA, 8'd3}, 2'd1);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL short_err: got %b, required 1", err);
        end
        send_beat(16'h0605, 2'd2);
        d = seq_data(1, 8);
        d[31:24] = 8'h00;
        q.push_back(mk(d, 8, 1'b1));
        send_beat(16'h0807, 2'd2);
        checks++;
        if ({out_fixed_data_vld, out_last} !== {8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL short_beat: got mask=%h last=%b, required ff 1", out_fixed_data_vld, out_last);
        end
        @(negedge clk);
        start_vec(2, 5'd2, 5'd2);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL short_err_clear: got %b, required 0", err);
        end
        q.push_back(mk(seq_data(9, 2), 2, 1'b1));
        send_beat(16'h0A09, 2'd2);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        start_vec(8, 5'd6, 5'd6);
        send_beat(16'h0201, 2'd2);
        send_beat(16'h0403, 2'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, out_fixed_data_vld} !== 9'h0) begin
            errors++;
            $display("FAIL rst_mid: got busy=%b mask=%h, required 0 00", busy, out_fixed_data_vld);
        end
        @(negedge clk);
        start_vec(2, 5'd3, 5'd3);
        q.push_back(mk(seq_data(17, 2), 2, 1'b1));
        send_beat(16'h1211, 2'd2);
        checks++;
        if ({out_fixed_data_vld, out_fixed_data[15:0]} !== {8'h03, 16'h1211}) begin
            errors++;
            $display("FAIL rst_restart: got mask=%h lo=%h, required 03 1211",
                     out_fixed_data_vld, out_fixed_data[15:0]);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero_len();
        test_basic();
        test_partial();
        test_len3();
        test_stall();
        test_short();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending beats, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/softmax_in_packer.md
Name: softmax_in_packer

Overview:
- Front-end directly upstream of the softmax pipeline.
- Accepts a narrow element stream of INT8 logits (IN_LANES per beat) and packs it into BUS_NUM-lane beats. Each output beat carries a contiguous low-lane valid mask, which the softmax max-search requires.
- Issues the per-vector scale-position configuration pulses, honours the downstream FIFO stall, and marks the final beat of each vector.

Parameters:
- BUS_NUM, 8, output lanes; must be a multiple of IN_LANES.
- IN_LANES, 2, input lanes per beat.
- FIXED_DATA_WIDTH, 8, element width (signed).
- SCALA_POS_WIDTH, 5, scale-position width (signed).
- LEN_WIDTH, 10, vector-length counter width; max length 2^LEN_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_start  in  1  start a vector; sampled only in IDLE.
- cfg_len  in  LEN_WIDTH  element count of the vector.
- cfg_in_scale_pos  in  SCALA_POS_WIDTH  input scale position.
- cfg_out_scale_pos  in  SCALA_POS_WIDTH  output scale position.
- in_data  in  IN_LANES*FIXED_DATA_WIDTH  elements; lane 0 is the earliest element.
- in_cnt  in  $clog2(IN_LANES+1)  valid low lanes in in_data.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- stall  in  1  downstream almost_full.
- in_scale_pos  out  SCALA_POS_WIDTH  to softmax.
- in_scale_pos_vld  out  1  one-cycle pulse.
- out_scale_pos  out  SCALA_POS_WIDTH  to softmax.
- out_scale_pos_vld  out  1  one-cycle pulse.
- out_fixed_data  out  BUS_NUM*FIXED_DATA_WIDTH  packed beat.
- out_fixed_data_vld  out  BUS_NUM  per-lane valid.
- out_last  out  1  final beat of the vector.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle pulse after the last beat.
- err  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs and registers are 0; state is IDLE.
- A reset mid-vector discards the partial pack buffer, and no beat is emitted.

States:
- IDLE: in_ready=0.
  - cfg_start with cfg_len!=0: latch len and both scale positions, clear err, go to CFG.
  - cfg_start with cfg_len==0: set err, stay in IDLE.
- CFG (1 cycle): in_scale_pos_vld=1 and out_scale_pos_vld=1, with the latched values; go to RUN.
- RUN: in_ready = ~stall (combinational).
  - Each handshake takes take = min(in_cnt, remaining) elements into the pack buffer at lane fill_ptr.
  - fill_ptr advances by IN_LANES (alignment is preserved); remaining decrements by take.
- DONE (1 cycle): done=1; go to IDLE.
- cfg_start outside IDLE is ignored.

Emission:
- When a handshake fills the buffer (fill_ptr+IN_LANES==BUS_NUM) or drives remaining to 0, the output registers load the buffer merged with the incoming lanes on the next edge.
- Latency is exactly 1 cycle from the completing handshake. fill_ptr returns to 0 in the same cycle.
- out_fixed_data_vld is high for 1 cycle and is a contiguous low mask ((1<<filled)-1). Invalid lanes are driven 0.
- out_last=1 with the beat where remaining reaches 0; the state moves RUN->DONE on that handshake.

Boundaries:
- Final beat with in_cnt>remaining: only remaining lanes are taken; no error.
- Short beat (in_cnt<IN_LANES) while remaining>in_cnt: set err. Missing lanes are zero-filled and counted as valid, so take=IN_LANES, capped at remaining.
- in_valid with in_cnt==0 is treated as a short beat.
- stall asserted in the same cycle as a completing beat: that beat is not accepted. The output holds 0/invalid until the handshake occurs.
- No output backpressure beyond stall; the output is never held across cycles.

Decomposition:
- Shared package softmax_pkg:
  - typedef fixed_t (signed FIXED_DATA_WIDTH).
  - typedef scale_pos_t.
  - enum state_t {IDLE, CFG, RUN, DONE}.
  - localparam BUS_NUM_DEFAULT.
- One natural sub-module: lane_packer, holding the buffer, fill_ptr, merge and mask generation. The FSM and counters live in the top.

Test Plan:
- len=8, 4 full beats 1..8, no stall -> CFG pulses 1 cycle after start. One out beat mask 0xFF, data 1..8, out_last=1, 1 cycle after the 4th handshake. done pulses the next cycle.
- len=13, 7 beats, last in_cnt=1 -> beat1 mask 0xFF elems 1-8. Beat2 mask 0x1F elems 9-13, out_last=1, lanes 5-7 =0.
- len=3, beats in_cnt=2, 2 -> second beat contributes 1 element. Mask 0x07, out_last=1, err=0.
- len=8 with stall high for 3 cycles mid-vector -> in_ready=0 during stall, no element lost or duplicated. Output beat delayed by 3 cycles with data identical to the no-stall case.
- len=8, second beat in_cnt=1 -> err=1; lane 3 =0. The beat still completes after 4 handshakes, mask 0xFF. err clears on the next accepted cfg_start.
- rst asserted after 2 beats of a len=8 vector -> no output beat, busy=0. A new cfg_start then runs cleanly from lane 0.
